// File: rtl/adder_pkg.sv
// Shared definitions for the nibble-serial adder.
//   NIBBLE  : slice width processed per clock by the ripple-carry adder
//   state_e : controller state encoding (binary)
package adder_pkg;

    localparam int NIBBLE = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// RCA: 4-bit ripple-carry adder, purely combinational.
// Ports:
//   A, B  in  4  addends
//   c_in  in  1  carry in
//   S     out 4  sum
//   c_out out 1  carry out of bit 3
module RCA (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       c_in,
    output logic [3:0] S,
    output logic       c_out
);

    logic [4:0] c;

    always_comb begin
        c    = '0;
        S    = '0;
        c[0] = c_in;
        for (int i = 0; i < 4; i++) begin
            S[i]     = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        c_out = c[4];
    end

endmodule

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder: WIDTH-bit adder that pushes one nibble per clock
// through a single shared RCA, chaining nibbles with a registered carry.
// Ports:
//   clk    in  1      rising-edge clock
//   rst    in  1      synchronous active-high reset
//   start  in  1      request, honoured in IDLE or DONE
//   a, b   in  WIDTH  operands, latched on an accepted start
//   c_in   in  1      carry into nibble 0, latched on an accepted start
//   busy   out 1      high while the nibble loop runs
//   done   out 1      one-cycle pulse when sum/c_out/ovf become valid
//   sum    out WIDTH  result, held until the next accepted start
//   c_out  out 1      carry out of the top nibble
//   ovf    out 1      two's-complement overflow flag (informational)
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int N  = WIDTH / NIBBLE;
    localparam int KW = $clog2(N);

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_out_q, c_out_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [NIBBLE-1:0] rca_a, rca_b, rca_s;
    logic              rca_co;

    // Current nibble of each latched operand feeds the shared adder.
    assign rca_a = a_q[int'(k_q) * NIBBLE +: NIBBLE];
    assign rca_b = b_q[int'(k_q) * NIBBLE +: NIBBLE];

    RCA u_rca (
        .A     (rca_a),
        .B     (rca_b),
        .c_in  (carry_q),
        .S     (rca_s),
        .c_out (rca_co)
    );

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        c_out_d = c_out_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            RUN: begin
                sum_d[int'(k_q) * NIBBLE +: NIBBLE] = rca_s;
                carry_d = rca_co;
                if (k_q == KW'(N - 1)) begin
                    // sum_d already holds the final top nibble here.
                    c_out_d = rca_co;
                    ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                              (sum_d[WIDTH-1] != a_q[WIDTH-1]);
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: begin
                // IDLE and DONE both accept a new request, which gives
                // back-to-back operation when start arrives during DONE.
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = c_in;
                    k_d     = '0;
                    sum_d   = '0;
                    c_out_d = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign sum   = sum_q;
    assign c_out = c_out_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed testbench for nibble_serial_adder (WIDTH=16).
module tb_nibble_serial_adder;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic             ovf;

    int n_checks;
    int n_errors;
    int n_cyc;

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .c_in  (c_in),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .c_out (c_out),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Present a request for one cycle; returns at the negedge after acceptance.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic cv);
        a     = av;
        b     = bv;
        c_in  = cv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count negedges until done is seen, bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy",  32'(busy),  0);
        check("rst_done",  32'(done),  0);
        check("rst_sum",   32'(sum),   0);
        check("rst_c_out", 32'(c_out), 0);
        check("rst_ovf",   32'(ovf),   0);
        rst = 1'b0;
        @(negedge clk);

        // 1 + 3
        issue(16'h0001, 16'h0003, 1'b0);
        check("t1_busy", 32'(busy), 1);
        wait_done(n_cyc);
        check("t1_latency", n_cyc, 4);
        check("t1_sum",   32'(sum),   32'h0004);
        check("t1_c_out", 32'(c_out), 0);
        check("t1_ovf",   32'(ovf),   0);
        @(negedge clk);
        check("t1_done_drop", 32'(done), 0);
        check("t1_idle", 32'(busy), 0);

        // All ones plus carry in
        issue(16'hFFFF, 16'hFFFF, 1'b1);
        wait_done(n_cyc);
        check("t2_latency", n_cyc, 4);
        check("t2_sum",   32'(sum),   32'hFFFF);
        check("t2_c_out", 32'(c_out), 1);
        check("t2_ovf",   32'(ovf),   0);
        @(negedge clk);

        // Signed overflow, with per-cycle view of the carry ripple
        issue(16'h7FFF, 16'h0001, 1'b0);
        @(negedge clk);
        check("t3_e1_sum", 32'(sum), 32'h0000);
        @(negedge clk);
        check("t3_e2_sum", 32'(sum), 32'h0000);
        @(negedge clk);
        check("t3_e3_sum", 32'(sum), 32'h0000);
        check("t3_e3_busy", 32'(busy), 1);
        @(negedge clk);
        check("t3_done",  32'(done),  1);
        check("t3_sum",   32'(sum),   32'h8000);
        check("t3_c_out", 32'(c_out), 0);
        check("t3_ovf",   32'(ovf),   1);
        @(negedge clk);

        // start while busy is ignored
        issue(16'h1234, 16'h1111, 1'b0);
        a     = 16'hFFFF;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        b     = 16'h0F0F;
        wait_done(n_cyc);
        check("t4_latency", n_cyc, 3);
        check("t4_sum", 32'(sum), 32'h2345);
        @(negedge clk);
        check("t4_done_once", 32'(done), 0);
        check("t4_no_restart", 32'(busy), 0);
        repeat (2) @(negedge clk);
        check("t4_still_idle", 32'(done), 0);

        // Reset in the second RUN cycle
        issue(16'hFFFF, 16'h0001, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy",  32'(busy),  0);
        check("t5_sum",   32'(sum),   0);
        check("t5_c_out", 32'(c_out), 0);
        check("t5_done",  32'(done),  0);
        repeat (5) @(negedge clk);
        check("t5_quiet", 32'(done), 0);
        issue(16'h0F0F, 16'h00F1, 1'b0);
        wait_done(n_cyc);
        check("t5_latency", n_cyc, 4);
        check("t5_sum",   32'(sum),   32'h1000);
        check("t5_c_out", 32'(c_out), 0);
        @(negedge clk);

        // Back-to-back, restart from DONE
        issue(16'h00FF, 16'h0001, 1'b0);
        wait_done(n_cyc);
        check("t6a_latency", n_cyc, 4);
        check("t6a_sum", 32'(sum), 32'h0100);
        issue(16'h8000, 16'h8000, 1'b0);
        check("t6_gap_done", 32'(done), 0);
        check("t6_gap_busy", 32'(busy), 1);
        check("t6_cleared",  32'(sum),  0);
        wait_done(n_cyc);
        check("t6_spacing", n_cyc + 1, 5);
        check("t6b_sum",   32'(sum),   32'h0000);
        check("t6b_c_out", 32'(c_out), 1);
        check("t6b_ovf",   32'(ovf),   1);
        @(negedge clk);
        check("t6b_done_drop", 32'(done), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
